// File: rtl/axi_pkg.sv
// Shared types for the register-bus responder: response codes, FSM states,
// and the request/response bundles exchanged with the register interconnect.
package axi_pkg;

    localparam int R_DWID = 32;
    localparam int R_AWID = 32;
    localparam int R_IDW  = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } t_AXI_RESP_e;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_ISSUE = 2'd1,
        WR_RESP  = 2'd2
    } t_reg_wr_st_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_RESP  = 2'd2
    } t_reg_rd_st_e;

    typedef struct packed {
        logic                  clk_en;
        logic                  awvalid;
        logic [R_AWID-1:0]     awaddr;
        logic [R_IDW-1:0]      awid;
        logic                  wvalid;
        logic [R_DWID-1:0]     wdata;
        logic [R_DWID/8-1:0]   wstrb;
        logic                  bready;
        logic                  arvalid;
        logic [R_AWID-1:0]     araddr;
        logic [R_IDW-1:0]      arid;
        logic                  rready;
    } t_reg_req_s;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic                  bvalid;
        t_AXI_RESP_e           bresp;
        logic [R_IDW-1:0]      bid;
        logic                  arready;
        logic                  rvalid;
        t_AXI_RESP_e           rresp;
        logic [R_IDW-1:0]      rid;
        logic [R_DWID-1:0]     rdata;
    } t_reg_resp_s;

endpackage

// File: rtl/reg_axi_decode.sv
// Window and alignment check for one address channel; yields the local word
// address and the error code to return if the access must be refused.
module reg_axi_decode
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0000_1000,
    parameter int          LADDR_W   = 10
) (
    input  logic [R_AWID-1:0]  i_addr,
    output logic [LADDR_W-1:0] o_laddr,
    output t_AXI_RESP_e        o_resp
);

    logic [R_AWID-1:0] w_off;

    // Addresses below the base wrap to a large offset and fall out of window.
    assign w_off   = i_addr - ADDR_BASE;
    assign o_laddr = w_off[LADDR_W+1:2];

    always_comb begin
        o_resp = OKAY;
        if (w_off >= ADDR_SIZE) begin
            o_resp = DECERR;
        end else if (i_addr[1:0] != 2'b00) begin
            o_resp = SLVERR;
        end
    end

endmodule

// File: rtl/reg_axi_slave.sv
// Register-bus responder: one outstanding write and one outstanding read,
// serialised onto a strobe/ack register-file port with timeout protection.
module reg_axi_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0000_1000,
    parameter int          TIMEOUT   = 16,
    parameter int          LADDR_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  t_reg_req_s           req,
    output t_reg_resp_s          resp,
    output logic [LADDR_W-1:0]   reg_addr,
    output logic                 reg_wr,
    output logic [R_DWID-1:0]    reg_wdata,
    output logic [R_DWID/8-1:0]  reg_wstrb,
    output logic                 reg_rd,
    input  logic [R_DWID-1:0]    reg_rdata,
    input  logic                 reg_ack,
    input  logic                 reg_err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    t_reg_wr_st_e         r_wr_st;
    logic                 r_aw_held, r_w_held;
    logic [R_AWID-1:0]    r_awaddr;
    logic [R_IDW-1:0]     r_awid;
    logic [R_DWID-1:0]    r_wdata_h;
    logic [R_DWID/8-1:0]  r_wstrb_h;
    logic                 r_bvalid;
    t_AXI_RESP_e          r_bresp;
    logic [R_IDW-1:0]     r_bid;

    t_reg_rd_st_e         r_rd_st;
    logic                 r_ar_held;
    logic [R_AWID-1:0]    r_araddr;
    logic [R_IDW-1:0]     r_arid;
    logic                 r_rvalid;
    t_AXI_RESP_e          r_rresp;
    logic [R_IDW-1:0]     r_rid;
    logic [R_DWID-1:0]    r_rdata;

    logic                 r_reg_wr, r_reg_rd;
    logic [LADDR_W-1:0]   r_reg_addr;
    logic [R_DWID-1:0]    r_reg_wdata;
    logic [R_DWID/8-1:0]  r_reg_wstrb;
    logic [15:0]          r_tcnt;

    logic                 w_awready, w_wready, w_arready;
    logic                 w_aw_hs, w_w_hs, w_ar_hs;
    logic [R_AWID-1:0]    w_aw_addr, w_ar_addr;
    logic [R_IDW-1:0]     w_aw_id, w_ar_id;
    logic [R_DWID-1:0]    w_wdata;
    logic [R_DWID/8-1:0]  w_wstrb;
    logic [LADDR_W-1:0]   w_aw_laddr, w_ar_laddr;
    t_AXI_RESP_e          w_aw_dec, w_ar_dec, w_acc_resp;
    logic                 w_wr_both, w_rd_both, w_wr_issue_req, w_rd_issue_req;
    logic                 w_wr_start, w_rd_start;
    logic                 w_strobe_on, w_tmo, w_strobe_end, w_port_free;

    assign w_awready = !rst && (r_wr_st == WR_IDLE) && !r_aw_held;
    assign w_wready  = !rst && (r_wr_st == WR_IDLE) && !r_w_held;
    assign w_arready = !rst && (r_rd_st == RD_IDLE) && !r_ar_held;

    assign w_aw_hs = req.clk_en && req.awvalid && w_awready;
    assign w_w_hs  = req.clk_en && req.wvalid  && w_wready;
    assign w_ar_hs = req.clk_en && req.arvalid && w_arready;

    // Effective channel payloads: the held copy if already captured, else the live bus.
    assign w_aw_addr = r_aw_held ? r_awaddr  : req.awaddr;
    assign w_aw_id   = r_aw_held ? r_awid    : req.awid;
    assign w_wdata   = r_w_held  ? r_wdata_h : req.wdata;
    assign w_wstrb   = r_w_held  ? r_wstrb_h : req.wstrb;
    assign w_ar_addr = r_ar_held ? r_araddr  : req.araddr;
    assign w_ar_id   = r_ar_held ? r_arid    : req.arid;

    reg_axi_decode #(.ADDR_BASE(ADDR_BASE), .ADDR_SIZE(ADDR_SIZE), .LADDR_W(LADDR_W))
        u_aw_dec (.i_addr(w_aw_addr), .o_laddr(w_aw_laddr), .o_resp(w_aw_dec));

    reg_axi_decode #(.ADDR_BASE(ADDR_BASE), .ADDR_SIZE(ADDR_SIZE), .LADDR_W(LADDR_W))
        u_ar_dec (.i_addr(w_ar_addr), .o_laddr(w_ar_laddr), .o_resp(w_ar_dec));

    assign w_wr_both      = (r_wr_st == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_rd_both      = (r_rd_st == RD_IDLE) && (r_ar_held || w_ar_hs);
    assign w_wr_issue_req = w_wr_both && (w_aw_dec == OKAY);
    assign w_rd_issue_req = w_rd_both && (w_ar_dec == OKAY);

    assign w_strobe_on  = r_reg_wr || r_reg_rd;
    assign w_tmo        = (TIMEOUT != 0) && (r_tcnt == TMO_LAST);
    assign w_strobe_end = w_strobe_on && (reg_ack || w_tmo);
    assign w_acc_resp   = (reg_ack && !reg_err) ? OKAY : SLVERR;
    // A strobe ending this cycle frees the port for a back-to-back start.
    assign w_port_free  = !w_strobe_on || w_strobe_end;
    assign w_wr_start   = req.clk_en && w_wr_issue_req && w_port_free;
    assign w_rd_start   = req.clk_en && w_rd_issue_req && w_port_free && !w_wr_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_st   <= WR_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_wdata_h <= '0;
            r_wstrb_h <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_bid     <= '0;
        end else if (req.clk_en) begin
            case (r_wr_st)
                WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= req.awaddr;
                        r_awid    <= req.awid;
                    end
                    if (w_w_hs) begin
                        r_w_held  <= 1'b1;
                        r_wdata_h <= req.wdata;
                        r_wstrb_h <= req.wstrb;
                    end
                    if (w_wr_both && (w_aw_dec != OKAY)) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bid     <= w_aw_id;
                        r_bresp   <= w_aw_dec;
                        r_bvalid  <= 1'b1;
                        r_wr_st   <= WR_RESP;
                    end else if (w_wr_start) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bid     <= w_aw_id;
                        r_wr_st   <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (r_reg_wr && w_strobe_end) begin
                        r_bresp  <= w_acc_resp;
                        r_bvalid <= 1'b1;
                        r_wr_st  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (req.bready) begin
                        r_bvalid <= 1'b0;
                        r_wr_st  <= WR_IDLE;
                    end
                end
                default: r_wr_st <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_st   <= RD_IDLE;
            r_ar_held <= 1'b0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rid     <= '0;
            r_rdata   <= '0;
        end else if (req.clk_en) begin
            case (r_rd_st)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar_held <= 1'b1;
                        r_araddr  <= req.araddr;
                        r_arid    <= req.arid;
                    end
                    if (w_rd_both && (w_ar_dec != OKAY)) begin
                        r_ar_held <= 1'b0;
                        r_rid     <= w_ar_id;
                        r_rresp   <= w_ar_dec;
                        r_rdata   <= '0;
                        r_rvalid  <= 1'b1;
                        r_rd_st   <= RD_RESP;
                    end else if (w_rd_start) begin
                        r_ar_held <= 1'b0;
                        r_rid     <= w_ar_id;
                        r_rd_st   <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (r_reg_rd && w_strobe_end) begin
                        r_rresp  <= w_acc_resp;
                        r_rdata  <= (w_acc_resp == OKAY) ? reg_rdata : '0;
                        r_rvalid <= 1'b1;
                        r_rd_st  <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (req.rready) begin
                        r_rvalid <= 1'b0;
                        r_rd_st  <= RD_IDLE;
                    end
                end
                default: r_rd_st <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wstrb <= '0;
            r_tcnt      <= '0;
        end else if (req.clk_en) begin
            if (w_wr_start) begin
                r_reg_wr    <= 1'b1;
                r_reg_rd    <= 1'b0;
                r_reg_addr  <= w_aw_laddr;
                r_reg_wdata <= w_wdata;
                r_reg_wstrb <= w_wstrb;
                r_tcnt      <= '0;
            end else if (w_rd_start) begin
                r_reg_wr   <= 1'b0;
                r_reg_rd   <= 1'b1;
                r_reg_addr <= w_ar_laddr;
                r_tcnt     <= '0;
            end else if (w_strobe_end) begin
                r_reg_wr <= 1'b0;
                r_reg_rd <= 1'b0;
                r_tcnt   <= '0;
            end else if (w_strobe_on) begin
                r_tcnt <= r_tcnt + 16'd1;
            end
        end
    end

    always_comb begin
        resp         = '0;
        resp.awready = w_awready;
        resp.wready  = w_wready;
        resp.bvalid  = r_bvalid;
        resp.bresp   = r_bresp;
        resp.bid     = r_bid;
        resp.arready = w_arready;
        resp.rvalid  = r_rvalid;
        resp.rresp   = r_rresp;
        resp.rid     = r_rid;
        resp.rdata   = r_rdata;
    end

    assign reg_addr  = r_reg_addr;
    assign reg_wr    = r_reg_wr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wstrb = r_reg_wstrb;
    assign reg_rd    = r_reg_rd;

endmodule

// File: tb/tb_reg_axi_slave.sv
// Directed bench for reg_axi_slave with a behavioural register-file responder.
module tb_reg_axi_slave;
    import axi_pkg::*;

    localparam int LADDR_W = 10;

    logic                 clk;
    logic                 rst;
    t_reg_req_s           req;
    t_reg_resp_s          resp;
    logic [LADDR_W-1:0]   reg_addr;
    logic                 reg_wr, reg_rd;
    logic [R_DWID-1:0]    reg_wdata, reg_rdata;
    logic [R_DWID/8-1:0]  reg_wstrb;
    logic                 reg_ack, reg_err;

    logic ack_en, ack_force, err_en, overlap;
    int   n_checks, n_fail, rd_hi_cnt;

    reg_axi_slave #(
        .ADDR_BASE(32'h0000_0000),
        .ADDR_SIZE(32'h0000_1000),
        .TIMEOUT  (16),
        .LADDR_W  (LADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .resp     (resp),
        .reg_addr (reg_addr),
        .reg_wr   (reg_wr),
        .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata),
        .reg_ack  (reg_ack),
        .reg_err  (reg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: acks in the strobe cycle when enabled; read data tags the address.
    always_comb begin
        reg_ack   = ack_force || (ack_en && (reg_wr || reg_rd));
        reg_err   = err_en;
        reg_rdata = 32'hA500_0000 | 32'(reg_addr);
    end

    always @(negedge clk) begin
        if (reg_rd) rd_hi_cnt = rd_hi_cnt + 1;
        if (reg_wr && reg_rd) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; rd_hi_cnt = 0; overlap = 1'b0;
        ack_en = 1'b1; ack_force = 1'b0; err_en = 1'b0;
        req = '0; req.clk_en = 1'b1;
        rst = 1'b1;
        cyc(3);
        check("rst_awready", 32'(resp.awready), 0);
        check("rst_arready", 32'(resp.arready), 0);
        check("rst_bvalid",  32'(resp.bvalid),  0);
        check("rst_rvalid",  32'(resp.rvalid),  0);
        check("rst_reg_wr",  32'(reg_wr),       0);
        check("rst_reg_addr", 32'(reg_addr),    0);
        rst = 1'b0;
        cyc(1);
        check("idle_awready", 32'(resp.awready), 1);
        check("idle_wready",  32'(resp.wready),  1);

        // Write 0x004, zero-wait ack
        req.awvalid = 1; req.awaddr = 32'h4; req.awid = 8'h11;
        req.wvalid = 1; req.wdata = 32'hDEADBEEF; req.wstrb = 4'hF; req.bready = 0;
        cyc(1);
        req.awvalid = 0; req.wvalid = 0;
        check("w1_reg_wr",    32'(reg_wr), 1);
        check("w1_reg_addr",  32'(reg_addr), 1);
        check("w1_wdata",     reg_wdata, 32'hDEADBEEF);
        check("w1_wstrb",     32'(reg_wstrb), 32'hF);
        check("w1_bvalid_early", 32'(resp.bvalid), 0);
        cyc(1);
        check("w1_reg_wr_off", 32'(reg_wr), 0);
        check("w1_bvalid",    32'(resp.bvalid), 1);
        check("w1_bresp",     32'(resp.bresp), 32'(OKAY));
        check("w1_bid",       32'(resp.bid), 32'h11);
        check("w1_awready_busy", 32'(resp.awready), 0);
        req.bready = 1;
        cyc(1);
        check("w1_bvalid_clr", 32'(resp.bvalid), 0);
        check("w1_awready_back", 32'(resp.awready), 1);

        // W three cycles ahead of AW
        req.wvalid = 1; req.wdata = 32'h12345678; req.wstrb = 4'h3;
        cyc(1);
        req.wvalid = 0;
        check("w2_wready_drop", 32'(resp.wready), 0);
        check("w2_awready",     32'(resp.awready), 1);
        cyc(2);
        check("w2_no_wr", 32'(reg_wr), 0);
        req.awvalid = 1; req.awaddr = 32'h10; req.awid = 8'h22;
        cyc(1);
        req.awvalid = 0;
        check("w2_reg_wr",   32'(reg_wr), 1);
        check("w2_reg_addr", 32'(reg_addr), 4);
        check("w2_wstrb",    32'(reg_wstrb), 3);
        cyc(1);
        check("w2_bvalid", 32'(resp.bvalid), 1);
        check("w2_bresp",  32'(resp.bresp), 32'(OKAY));
        check("w2_bid",    32'(resp.bid), 32'h22);
        cyc(1);

        // Decode errors on the read path
        req.rready = 0; req.arvalid = 1; req.araddr = 32'h1000; req.arid = 8'h33;
        cyc(1);
        req.arvalid = 0;
        check("r_dec_rvalid", 32'(resp.rvalid), 1);
        check("r_dec_rresp",  32'(resp.rresp), 32'(DECERR));
        check("r_dec_rdata",  resp.rdata, 0);
        check("r_dec_no_rd",  32'(reg_rd), 0);
        check("r_dec_rid",    32'(resp.rid), 32'h33);
        req.rready = 1;
        cyc(1);
        check("r_dec_clr", 32'(resp.rvalid), 0);
        req.arvalid = 1; req.araddr = 32'h2; req.arid = 8'h34;
        cyc(1);
        req.arvalid = 0;
        check("r_mis_rresp", 32'(resp.rresp), 32'(SLVERR));
        check("r_mis_no_rd", 32'(reg_rd), 0);
        cyc(1);

        // Read timeout, then a late ack
        ack_en = 0; req.rready = 0; rd_hi_cnt = 0;
        req.arvalid = 1; req.araddr = 32'h8; req.arid = 8'h44;
        cyc(1);
        req.arvalid = 0;
        check("to_reg_rd",   32'(reg_rd), 1);
        check("to_reg_addr", 32'(reg_addr), 2);
        cyc(15);
        check("to_rd_last",  32'(reg_rd), 1);
        check("to_rvalid_early", 32'(resp.rvalid), 0);
        cyc(1);
        check("to_rd_drop",  32'(reg_rd), 0);
        check("to_rvalid",   32'(resp.rvalid), 1);
        check("to_rresp",    32'(resp.rresp), 32'(SLVERR));
        ack_force = 1;
        cyc(2);
        ack_force = 0;
        check("to_late_rvalid", 32'(resp.rvalid), 1);
        check("to_late_rresp",  32'(resp.rresp), 32'(SLVERR));
        check("to_late_rdata",  resp.rdata, 0);
        check("to_rd_cycles",   32'(rd_hi_cnt), 16);
        check("to_rid",         32'(resp.rid), 32'h44);
        req.rready = 1;
        cyc(1);
        req.rready = 0;

        // Write and read arrive together; write owns the port first
        ack_en = 1; req.bready = 0;
        req.awvalid = 1; req.awaddr = 32'h20; req.awid = 8'h55;
        req.wvalid = 1; req.wdata = 32'hCAFEF00D; req.wstrb = 4'hF;
        req.arvalid = 1; req.araddr = 32'hC; req.arid = 8'h66;
        cyc(1);
        req.awvalid = 0; req.wvalid = 0; req.arvalid = 0;
        check("cc_reg_wr",   32'(reg_wr), 1);
        check("cc_reg_rd0",  32'(reg_rd), 0);
        check("cc_addr_wr",  32'(reg_addr), 8);
        check("cc_arready",  32'(resp.arready), 0);
        cyc(1);
        check("cc_reg_rd",   32'(reg_rd), 1);
        check("cc_addr_rd",  32'(reg_addr), 3);
        check("cc_bvalid",   32'(resp.bvalid), 1);
        check("cc_bid",      32'(resp.bid), 32'h55);
        cyc(1);
        check("cc_rvalid",   32'(resp.rvalid), 1);
        check("cc_rresp",    32'(resp.rresp), 32'(OKAY));
        check("cc_rid",      32'(resp.rid), 32'h66);
        check("cc_rdata",    resp.rdata, 32'hA500_0003);
        check("cc_bresp",    32'(resp.bresp), 32'(OKAY));
        check("cc_bvalid_held", 32'(resp.bvalid), 1);
        req.bready = 1; req.rready = 1;
        cyc(1);
        check("cc_b_clr", 32'(resp.bvalid), 0);
        check("cc_r_clr", 32'(resp.rvalid), 0);
        req.rready = 0;

        // reg_err on a write maps to SLVERR
        err_en = 1; req.bready = 0;
        req.awvalid = 1; req.awaddr = 32'h30; req.awid = 8'h5A;
        req.wvalid = 1; req.wdata = 32'h1;
        cyc(1);
        req.awvalid = 0; req.wvalid = 0;
        cyc(1);
        check("err_bresp", 32'(resp.bresp), 32'(SLVERR));
        err_en = 0; req.bready = 1;
        cyc(1);

        // clk_en gating with responses held, then reset mid-read
        req.bready = 0;
        req.awvalid = 1; req.awaddr = 32'h40; req.awid = 8'h77;
        req.wvalid = 1; req.wdata = 32'h2;
        cyc(1);
        req.awvalid = 0; req.wvalid = 0;
        check("ce_reg_wr", 32'(reg_wr), 1);
        cyc(1);
        check("ce_bvalid", 32'(resp.bvalid), 1);
        ack_en = 0;
        req.arvalid = 1; req.araddr = 32'h14; req.arid = 8'h88;
        cyc(1);
        req.arvalid = 0;
        check("ce_reg_rd",   32'(reg_rd), 1);
        check("ce_reg_addr", 32'(reg_addr), 5);
        for (int i = 0; i < 5; i++) begin
            req.clk_en = (i % 2) == 1;
            cyc(1);
            check("ce_hold_rd",     32'(reg_rd), 1);
            check("ce_hold_bvalid", 32'(resp.bvalid), 1);
            check("ce_hold_rvalid", 32'(resp.rvalid), 0);
        end
        req.clk_en = 0; req.bready = 1;
        cyc(1);
        check("ce_no_hs_bvalid", 32'(resp.bvalid), 1);
        rst = 1; req.bready = 0;
        cyc(1);
        check("mid_rst_reg_rd", 32'(reg_rd), 0);
        check("mid_rst_rvalid", 32'(resp.rvalid), 0);
        check("mid_rst_bvalid", 32'(resp.bvalid), 0);
        rst = 0; req.clk_en = 1;
        cyc(1);
        check("post_rst_awready", 32'(resp.awready), 1);
        check("post_rst_arready", 32'(resp.arready), 1);
        check("no_overlap", 32'(overlap), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
